rtc_bcd_clock: RTL and testbench

//  Parametrised real-time clock: keeps hh:mm:ss in BCD from one system clock, with a run enable.

---
 rtl/rtc_pkg.sv | 37 +++
 rtl/rtc_prescaler.sv | 35 +++
 rtl/rtc_bcd_clock.sv | 156 +++++++++++++++
 tb/tb_rtc_bcd_clock.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types, limits and time validation for the BCD real-time clock.
package rtc_pkg;

    typedef logic [3:0] bcd_t;

    // Field order matches the {hh,mm,ss} load word, so a 24-bit value casts directly.
    typedef struct packed {
        bcd_t hh_t;
        bcd_t hh_o;
        bcd_t mm_t;
        bcd_t mm_o;
        bcd_t ss_t;
        bcd_t ss_o;
    } rtc_time_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } rtc_load_st_e;

    localparam logic [7:0] MAX_HH = 8'h23;
    localparam logic [7:0] MAX_MS = 8'h59;

    // A time is valid when every digit is decimal and each field is in range.
    // BCD compares like binary once every digit is <= 9.
    function automatic logic time_valid(input rtc_time_t t);
        logic digits_ok;
        digits_ok = (t.hh_t <= 4'd9) && (t.hh_o <= 4'd9) &&
                    (t.mm_t <= 4'd9) && (t.mm_o <= 4'd9) &&
                    (t.ss_t <= 4'd9) && (t.ss_o <= 4'd9);
        return digits_ok &&
               ({t.hh_t, t.hh_o} <= MAX_HH) &&
               ({t.mm_t, t.mm_o} <= MAX_MS) &&
               ({t.ss_t, t.ss_o} <= MAX_MS);
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Cycle divider: counts 0..CLK_HZ-1 while enabled and not held, strobing at terminal count.
module rtc_prescaler #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic hold,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] TC = W'(CLK_HZ - 1);

    logic [W-1:0] cnt;
    logic         run;

    assign run  = en && !hold;
    // The strobe is combinational so the parent can register its effect on the same edge as the wrap.
    assign tick = run && (cnt == TC);

    // Count while running; clear has priority so a committed load restarts the second.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rtc_bcd_clock.sv
// BCD hh:mm:ss real-time clock with run enable, 12h/24h display and validated load.
module rtc_bcd_clock
    import rtc_pkg::*;
#(
    parameter int         CLK_HZ  = 100_000_000,
    parameter logic [7:0] INIT_HH = 8'h12,
    parameter logic [7:0] INIT_MM = 8'h00
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        mode_12h,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [23:0] load_time,
    output logic        load_err,
    output logic [3:0]  hh_t,
    output logic [3:0]  hh_o,
    output logic [3:0]  mm_t,
    output logic [3:0]  mm_o,
    output logic [3:0]  ss_t,
    output logic [3:0]  ss_o,
    output logic        pm,
    output logic        tick_sec,
    output logic        tick_min
);

    localparam rtc_time_t INIT_TIME = rtc_time_t'({INIT_HH, INIT_MM, 8'h00});

    rtc_time_t    tm;
    rtc_time_t    tm_inc;
    rtc_time_t    staged;
    rtc_load_st_e st;
    logic         sec_wrap;
    logic         ps_tick;
    logic         stage_ok;
    logic [4:0]   hr_bin;
    logic [4:0]   hr_12;

    assign stage_ok = time_valid(staged);

    rtc_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .hold (st == CHECK),
        .clr  ((st == CHECK) && stage_ok),
        .tick (ps_tick)
    );

    // Digit cascade: next time after one second, 23:59:59 wrapping to 00:00:00.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        tm_inc   = tm;
        sec_wrap = 1'b0;
        if (tm.ss_o != 4'd9) begin
            tm_inc.ss_o = tm.ss_o + 4'd1;
        end else begin
            tm_inc.ss_o = 4'd0;
            if (tm.ss_t != 4'd5) begin
                tm_inc.ss_t = tm.ss_t + 4'd1;
            end else begin
                tm_inc.ss_t = 4'd0;
                sec_wrap    = 1'b1;
                if (tm.mm_o != 4'd9) begin
                    tm_inc.mm_o = tm.mm_o + 4'd1;
                end else begin
                    tm_inc.mm_o = 4'd0;
                    if (tm.mm_t != 4'd5) begin
                        tm_inc.mm_t = tm.mm_t + 4'd1;
                    end else begin
                        tm_inc.mm_t = 4'd0;
                        if ({tm.hh_t, tm.hh_o} == MAX_HH) begin
                            tm_inc.hh_t = 4'd0;
                            tm_inc.hh_o = 4'd0;
                        end else if (tm.hh_o == 4'd9) begin
                            tm_inc.hh_o = 4'd0;
                            tm_inc.hh_t = tm.hh_t + 4'd1;
                        end else begin
                            tm_inc.hh_o = tm.hh_o + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Load FSM, time register and tick pulses; reset wins over both commit and tick.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tm         <= INIT_TIME;
            staged     <= '0;
            st         <= IDLE;
            load_ready <= 1'b1;
            load_err   <= 1'b0;
            tick_sec   <= 1'b0;
            tick_min   <= 1'b0;
        end else begin
            tick_sec <= 1'b0;
            tick_min <= 1'b0;
            case (st)
                IDLE: begin
                    if (ps_tick) begin
                        tm       <= tm_inc;
                        tick_sec <= 1'b1;
                        tick_min <= sec_wrap;
                    end
                    // load_ready mirrors IDLE, so load_valid alone qualifies the handshake here.
                    if (load_valid) begin
                        staged     <= rtc_time_t'(load_time);
                        st         <= CHECK;
                        load_ready <= 1'b0;
                    end
                end
                CHECK: begin
                    if (stage_ok) begin
                        tm       <= staged;
                        load_err <= 1'b0;
                    end else begin
                        load_err <= 1'b1;
                    end
                    st         <= IDLE;
                    load_ready <= 1'b1;
                end
                default: begin
                    st         <= IDLE;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

    // Display mapping: 12h mode folds 00 to 12 and 13..23 to 01..11; minutes and seconds pass through.
    always_comb begin
        hr_bin = 5'(tm.hh_t) * 5'd10 + 5'(tm.hh_o);
        hr_12  = hr_bin;
        if (hr_bin == 5'd0) begin
            hr_12 = 5'd12;
        end else if (hr_bin > 5'd12) begin
            hr_12 = hr_bin - 5'd12;
        end
        hh_t = tm.hh_t;
        hh_o = tm.hh_o;
        if (mode_12h) begin
            hh_t = (hr_12 >= 5'd10) ? 4'd1 : 4'd0;
            hh_o = (hr_12 >= 5'd10) ? 4'(hr_12 - 5'd10) : 4'(hr_12);
        end
    end

    assign mm_t = tm.mm_t;
    assign mm_o = tm.mm_o;
    assign ss_t = tm.ss_t;
    assign ss_o = tm.ss_o;
    assign pm   = ({tm.hh_t, tm.hh_o} >= 8'h12);

endmodule

// File: tb/tb_rtc_bcd_clock.sv
// Directed bench for rtc_bcd_clock with a 10-cycle second.
module tb_rtc_bcd_clock;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        mode_12h;
    logic        load_valid;
    logic        load_ready;
    logic [23:0] load_time;
    logic        load_err;
    logic [3:0]  hh_t, hh_o, mm_t, mm_o, ss_t, ss_o;
    logic        pm;
    logic        tick_sec;
    logic        tick_min;

    int total = 0;
    int bad   = 0;

    rtc_bcd_clock #(
        .CLK_HZ  (10),
        .INIT_HH (8'h12),
        .INIT_MM (8'h00)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .mode_12h   (mode_12h),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_time  (load_time),
        .load_err   (load_err),
        .hh_t       (hh_t),
        .hh_o       (hh_o),
        .mm_t       (mm_t),
        .mm_o       (mm_o),
        .ss_t       (ss_t),
        .ss_o       (ss_o),
        .pm         (pm),
        .tick_sec   (tick_sec),
        .tick_min   (tick_min)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n active edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] now_time();
        return {hh_t, hh_o, mm_t, mm_o, ss_t, ss_o};
    endfunction

    // Single-beat load: capture edge, then the check edge.
    task automatic do_load(input logic [23:0] t);
        load_valid = 1'b1;
        load_time  = t;
        step(1);
        load_valid = 1'b0;
        step(1);
    endtask

    initial begin
        int ticks;
        rstn       = 1'b0;
        en         = 1'b0;
        mode_12h   = 1'b0;
        load_valid = 1'b0;
        load_time  = '0;
        step(2);
        rstn = 1'b1;

        // 1. Reset state and first second
        check("rst_time",  now_time(), 24'h120000);
        check("rst_pm",    24'(pm), 24'd1);
        check("rst_ready", 24'(load_ready), 24'd1);
        check("rst_err",   24'(load_err), 24'd0);
        check("rst_tick",  24'(tick_sec), 24'd0);
        en = 1'b1;
        step(9);
        check("pre_tick_time", now_time(), 24'h120000);
        check("pre_tick",      24'(tick_sec), 24'd0);
        step(1);
        check("sec1_time",   now_time(), 24'h120001);
        check("sec1_tick",   24'(tick_sec), 24'd1);
        check("sec1_tmin",   24'(tick_min), 24'd0);
        en = 1'b0;
        step(1);
        check("tick_pulse1", 24'(tick_sec), 24'd0);

        // 2. Midnight rollover
        do_load(24'h235959);
        check("ld_2359",     now_time(), 24'h235959);
        check("ld_2359_err", 24'(load_err), 24'd0);
        check("ld_2359_pm",  24'(pm), 24'd1);
        en = 1'b1;
        step(9);
        check("pre_wrap",    now_time(), 24'h235959);
        step(1);
        check("wrap_time",   now_time(), 24'h000000);
        check("wrap_tsec",   24'(tick_sec), 24'd1);
        check("wrap_tmin",   24'(tick_min), 24'd1);
        check("wrap_pm",     24'(pm), 24'd0);
        en = 1'b0;

        // 3. Rejected load, then a good load that restarts the prescaler
        do_load(24'h245900);
        check("bad_err",  24'(load_err), 24'd1);
        check("bad_time", now_time(), 24'h000000);
        en = 1'b1;
        step(4);
        do_load(24'h075930);
        check("good_err",  24'(load_err), 24'd0);
        check("good_time", now_time(), 24'h075930);
        step(9);
        check("restart_hold", now_time(), 24'h075930);
        step(1);
        check("restart_tick", now_time(), 24'h075931);
        check("restart_tsec", 24'(tick_sec), 24'd1);
        en = 1'b0;

        // 4. 12h display mapping
        do_load(24'h003000);
        mode_12h = 1'b1;
        #1;
        check("m12_00_hh", {16'h0, hh_t, hh_o}, 24'h12);
        check("m12_00_pm", 24'(pm), 24'd0);
        check("m12_00_mm", now_time() & 24'h00FFFF, 24'h003000);
        do_load(24'h130500);
        check("m12_13_hh", {16'h0, hh_t, hh_o}, 24'h01);
        check("m12_13_pm", 24'(pm), 24'd1);
        do_load(24'h230000);
        check("m12_23_hh", {16'h0, hh_t, hh_o}, 24'h11);
        do_load(24'h120000);
        check("m12_12_hh", {16'h0, hh_t, hh_o}, 24'h12);
        do_load(24'h130500);
        mode_12h = 1'b0;
        #1;
        check("m24_13", now_time(), 24'h130500);

        // 5. Back-to-back load_valid, then a long freeze
        load_valid = 1'b1;
        load_time  = 24'h010000;
        check("rdy0", 24'(load_ready), 24'd1);
        step(1);
        check("rdy1", 24'(load_ready), 24'd0);
        step(1);
        check("rdy2", 24'(load_ready), 24'd1);
        step(1);
        check("rdy3", 24'(load_ready), 24'd0);
        load_valid = 1'b0;
        step(1);
        check("rdy4",      24'(load_ready), 24'd1);
        check("rdy_time",  now_time(), 24'h010000);
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (tick_sec) ticks++;
        end
        check("frz_ticks", 24'(ticks), 24'd0);
        check("frz_time",  now_time(), 24'h010000);

        // 6. Reset during CHECK discards the staged load
        do_load(24'h250000);
        check("pre_rst_err", 24'(load_err), 24'd1);
        load_valid = 1'b1;
        load_time  = 24'h010203;
        step(1);
        check("in_check", 24'(load_ready), 24'd0);
        rstn       = 1'b0;
        load_valid = 1'b0;
        step(1);
        rstn = 1'b1;
        check("mid_rst_time",  now_time(), 24'h120000);
        check("mid_rst_err",   24'(load_err), 24'd0);
        check("mid_rst_ready", 24'(load_ready), 24'd1);
        step(2);
        check("no_commit", now_time(), 24'h120000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
